pps_phase_detect: RTL and testbench
===================================

Name: pps_phase_detect

Overview:
Time-interval counter placed directly downstream of the local 1PPS divider in the GPSDO loop. It measures the signed offset, in CLK_SYS cycles, between the rising edge of the GPS 1PPS and the rising edge of the locally generated 1PPS. Each completed measurement is handed to the loop-filter/DAC stage as a one-cycle valid-qualified word. It also flags measurement timeouts and loss of the GPS 1PPS.

Parameters:
CNT_W, 28, width of the signed phase_err output and the interval counter
MAX_WIN, 50_000_000, maximum interval in CLK_SYS cycles before a measurement is aborted (0.5 s at 100 MHz)
LOSS_CYC, 150_000_000, CLK_SYS cycles without a GPS edge before gps_lost is set
SYNC_STAGES, 2, flip-flop synchronizer depth on each PPS input (>=2)

Ports:
CLK_SYS  in  1  system clock; sole clock of the block
CLK_RST  in  1  reset, synchronous to CLK_SYS, active-low
_1PPS_GPS  in  1  GPS receiver 1PPS, asynchronous
_1PPS_Local  in  1  local 1PPS from the divider, asynchronous to CLK_SYS
phase_err  out  CNT_W  signed interval; positive means GPS edge leads local edge
phase_valid  out  1  one-cycle strobe; phase_err is valid in that cycle
meas_timeout  out  1  one-cycle strobe; measurement aborted at MAX_WIN
gps_lost  out  1  level; GPS 1PPS is absent

Behaviour:
- Reset is synchronous on CLK_SYS when CLK_RST=0. Reset values: phase_err=0, phase_valid=0, meas_timeout=0, gps_lost=1, FSM=IDLE, counters=0, synchronizers=0.
- Input conditioning: each input passes through SYNC_STAGES flip-flops, then a rising-edge detector that produces a one-cycle pulse. Both paths have identical latency, so the measured difference is unaffected.
- FSM states and transitions:
  - IDLE
    - GPS pulse only -> WAIT_LOCAL, cnt=0.
    - Local pulse only -> WAIT_GPS, cnt=0.
    - Both pulses in the same cycle -> phase_err=0 and phase_valid=1 in the next cycle; stay in IDLE.
  - WAIT_LOCAL
    - cnt increments by 1 each cycle.
    - Local pulse when cnt has reached k -> phase_err=+k and phase_valid=1 in the next cycle -> IDLE.
    - A second GPS pulse before the local pulse -> restart: cnt=0, stay in WAIT_LOCAL.
  - WAIT_GPS: mirror of WAIT_LOCAL. The result is phase_err=-k, and a repeated local pulse restarts the count.
  - Timeout: if cnt==MAX_WIN-1 and no closing pulse arrives, meas_timeout=1 in the next cycle -> IDLE; phase_err is unchanged.
  - Closing pulse together with a new opening pulse in the same cycle: close the measurement. The opening pulse is consumed as the closing edge only and does not start a new measurement.
- phase_err holds its value between valid strobes. Two's-complement, width CNT_W. MAX_WIN must be < 2^(CNT_W-1); this is checked at elaboration.
- gps_lost:
  - A loss counter clears on every GPS pulse and otherwise increments, saturating at LOSS_CYC.
  - gps_lost=1 when the count reaches LOSS_CYC.
  - gps_lost=0 in the cycle after any GPS pulse.
- Reset asserted mid-measurement: the measurement is abandoned with no valid or timeout strobe. Reset values apply on the next edge.
- Latency from input pin edge to internal pulse = SYNC_STAGES+1 cycles. Result latency = 1 cycle after the closing pulse.

Optional Feature:
PHASE_AVG_EN
- Defined:
  - Completed measurements accumulate in a signed CNT_W+2 sum.
  - After every 4th measurement: phase_err = sum >>> 2 (arithmetic shift, floors toward -inf), phase_valid=1, then the sum and sample count clear.
  - A timeout or gps_lost=1 clears the sum and sample count without a strobe.
  - meas_timeout is unchanged.
- Undefined: every measurement is output directly, as specified above.

Test Plan:
1. GPS rising edge, local rising edge 1000 cycles later -> one phase_valid, phase_err=+1000.
2. Local edge, GPS edge 37 cycles later -> phase_err=-37; no meas_timeout.
3. Both inputs rise in the same CLK_SYS cycle -> phase_valid with phase_err=0. Also: GPS edge, second GPS edge 500 cycles later, local edge 20 cycles after that -> phase_err=+20.
4. GPS edge only, MAX_WIN=1000 -> meas_timeout one cycle after the count reaches 999; phase_valid never asserted; FSM returns to IDLE.
5. gps_lost: after reset gps_lost=1; a GPS edge clears it; no further GPS edge for LOSS_CYC (bench LOSS_CYC=2000) cycles -> gps_lost=1. Reset pulsed mid-WAIT_LOCAL -> no strobe, outputs return to reset values.
6. PHASE_AVG_EN: measurements +10, +11, -3, +5 -> one strobe after the 4th with phase_err=+5 (23>>>2). Measurements -1, -1, -1, -2 -> phase_err=-2.

Source files
------------

// File: rtl/pps_phase_detect.sv
// pps_phase_detect: signed time-interval counter between the GPS 1PPS and
// the local 1PPS, in CLK_SYS cycles. Positive phase_err means the GPS edge
// leads the local edge. Also flags aborted measurements and GPS 1PPS loss.
// Optional feature macro: PHASE_AVG_EN (averages every 4 measurements).
module pps_phase_detect #(
    parameter int CNT_W       = 28,
    parameter int MAX_WIN     = 50_000_000,
    parameter int LOSS_CYC    = 150_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    CLK_SYS,
    input  logic                    CLK_RST,
    input  logic                    _1PPS_GPS,
    input  logic                    _1PPS_Local,
    output logic signed [CNT_W-1:0] phase_err,
    output logic                    phase_valid,
    output logic                    meas_timeout,
    output logic                    gps_lost
);

    localparam int                LOSS_W      = $clog2(LOSS_CYC + 1);
    localparam logic [CNT_W-1:0]  LP_CNT_LAST = CNT_W'(MAX_WIN - 1);
    localparam logic [CNT_W-1:0]  LP_CNT_ONE  = CNT_W'(1);
    localparam logic [LOSS_W-1:0] LP_LOSS_MAX = LOSS_W'(LOSS_CYC);
    localparam logic [LOSS_W-1:0] LP_LOSS_ONE = LOSS_W'(1);

    // Parameter sanity, evaluated at elaboration
    generate
        if (longint'(MAX_WIN) >= (longint'(1) << (CNT_W - 1))) begin : g_bad_win
            $error("pps_phase_detect: MAX_WIN must be below 2**(CNT_W-1)");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("pps_phase_detect: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LOCAL,
        ST_WAIT_GPS
    } state_t;

    logic [SYNC_STAGES-1:0]  r_gps_sync;
    logic [SYNC_STAGES-1:0]  r_loc_sync;
    logic                    r_gps_prev;
    logic                    r_loc_prev;
    logic                    r_gps_pulse;
    logic                    r_loc_pulse;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [LOSS_W-1:0]       r_loss;

    logic signed [CNT_W-1:0] r_phase_err;
    logic                    r_phase_valid;
    logic                    r_meas_timeout;
    logic                    r_gps_lost;

    logic [CNT_W-1:0]        w_cnt_inc;
    logic [LOSS_W-1:0]       w_loss_inc;
    logic                    w_done;
    logic                    w_tmo;
    logic signed [CNT_W-1:0] w_val;

`ifdef PHASE_AVG_EN
    logic signed [CNT_W+1:0] r_sum;
    logic [1:0]              r_nsamp;
    logic signed [CNT_W+1:0] w_sum_next;

    assign w_sum_next = r_sum + {{2{w_val[CNT_W-1]}}, w_val};
`endif

    assign w_cnt_inc  = r_cnt + LP_CNT_ONE;
    assign w_loss_inc = r_loss + LP_LOSS_ONE;

    // Synchronize both PPS inputs and turn rising edges into one-cycle pulses
    always_ff @(posedge CLK_SYS) begin
        if (!CLK_RST) begin
            r_gps_sync  <= '0;
            r_loc_sync  <= '0;
            r_gps_prev  <= 1'b0;
            r_loc_prev  <= 1'b0;
            r_gps_pulse <= 1'b0;
            r_loc_pulse <= 1'b0;
        end else begin
            r_gps_sync  <= {r_gps_sync[SYNC_STAGES-2:0], _1PPS_GPS};
            r_loc_sync  <= {r_loc_sync[SYNC_STAGES-2:0], _1PPS_Local};
            r_gps_prev  <= r_gps_sync[SYNC_STAGES-1];
            r_loc_prev  <= r_loc_sync[SYNC_STAGES-1];
            r_gps_pulse <= r_gps_sync[SYNC_STAGES-1] & ~r_gps_prev;
            r_loc_pulse <= r_loc_sync[SYNC_STAGES-1] & ~r_loc_prev;
        end
    end

    // Decode measurement completion / abort for the current cycle.
    // The closing edge counts the current cycle, so the result is cnt+1.
    always_comb begin
        w_done = 1'b0;
        w_tmo  = 1'b0;
        w_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_gps_pulse && r_loc_pulse) begin
                    w_done = 1'b1;
                end
            end
            ST_WAIT_LOCAL: begin
                if (r_loc_pulse) begin
                    w_done = 1'b1;
                    w_val  = $signed(w_cnt_inc);
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_tmo = 1'b1;
                end
            end
            ST_WAIT_GPS: begin
                if (r_gps_pulse) begin
                    w_done = 1'b1;
                    w_val  = -$signed(w_cnt_inc);
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_tmo = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Measurement FSM with registered result/strobe outputs
    always_ff @(posedge CLK_SYS) begin
        if (!CLK_RST) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_phase_err    <= '0;
            r_phase_valid  <= 1'b0;
            r_meas_timeout <= 1'b0;
`ifdef PHASE_AVG_EN
            r_sum          <= '0;
            r_nsamp        <= '0;
`endif
        end else begin
            r_phase_valid  <= 1'b0;
            r_meas_timeout <= w_tmo;

            case (r_state)
                ST_IDLE: begin
                    if (r_gps_pulse && !r_loc_pulse) begin
                        r_state <= ST_WAIT_LOCAL;
                        r_cnt   <= '0;
                    end else if (r_loc_pulse && !r_gps_pulse) begin
                        r_state <= ST_WAIT_GPS;
                        r_cnt   <= '0;
                    end
                end
                // A closing edge wins over a coincident re-opening edge
                ST_WAIT_LOCAL: begin
                    if (w_done || w_tmo) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_gps_pulse) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_WAIT_GPS: begin
                    if (w_done || w_tmo) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_loc_pulse) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase

`ifdef PHASE_AVG_EN
            if (w_tmo || r_gps_lost) begin
                r_sum   <= '0;
                r_nsamp <= '0;
            end else if (w_done) begin
                if (r_nsamp == 2'd3) begin
                    r_phase_err   <= w_sum_next[CNT_W+1:2];
                    r_phase_valid <= 1'b1;
                    r_sum         <= '0;
                    r_nsamp       <= '0;
                end else begin
                    r_sum   <= w_sum_next;
                    r_nsamp <= r_nsamp + 2'd1;
                end
            end
`else
            if (w_done) begin
                r_phase_err   <= w_val;
                r_phase_valid <= 1'b1;
            end
`endif
        end
    end

    // GPS loss watchdog: saturating count of cycles since the last GPS edge
    always_ff @(posedge CLK_SYS) begin
        if (!CLK_RST) begin
            r_loss     <= '0;
            r_gps_lost <= 1'b1;
        end else if (r_gps_pulse) begin
            r_loss     <= '0;
            r_gps_lost <= 1'b0;
        end else begin
            if (r_loss != LP_LOSS_MAX) begin
                r_loss <= w_loss_inc;
            end
            if (w_loss_inc == LP_LOSS_MAX) begin
                r_gps_lost <= 1'b1;
            end
        end
    end

    assign phase_err    = r_phase_err;
    assign phase_valid  = r_phase_valid;
    assign meas_timeout = r_meas_timeout;
    assign gps_lost     = r_gps_lost;

endmodule

// File: tb/tb_pps_phase_detect.sv
// Testbench for pps_phase_detect: table of edge-timing vectors plus
// hand-written reset and GPS-loss sequences, checked through a scoreboard.
module tb_pps_phase_detect;

    localparam int CNT_W    = 28;
    localparam int MAX_WIN  = 1000;
    localparam int LOSS_CYC = 2000;
    localparam int SYNC     = 2;
    // pin edge -> internal pulse is SYNC+1 cycles, result one cycle later
    localparam int LAT      = SYNC + 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    gps = 1'b0;
    logic                    loc = 1'b0;
    logic signed [CNT_W-1:0] phase_err;
    logic                    phase_valid;
    logic                    meas_timeout;
    logic                    gps_lost;

    pps_phase_detect #(
        .CNT_W      (CNT_W),
        .MAX_WIN    (MAX_WIN),
        .LOSS_CYC   (LOSS_CYC),
        .SYNC_STAGES(SYNC)
    ) dut (
        .CLK_SYS     (clk),
        .CLK_RST     (rst_n),
        ._1PPS_GPS   (gps),
        ._1PPS_Local (loc),
        .phase_err   (phase_err),
        .phase_valid (phase_valid),
        .meas_timeout(meas_timeout),
        .gps_lost    (gps_lost)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit     tmo;
        longint err;
        longint at;
    } exp_t;

    exp_t   exp_q[$];
    longint exp_last_err = 0;

    typedef struct {
        string name;
        int    g1;
        int    g2;
        int    l1;
        int    l2;
        bit    push;
        bit    tmo;
        int    err;
        int    close_t;
    } vec_t;

    // Scoreboard consumer: every strobe must match the oldest expectation
    exp_t   mon_e;
    longint mon_err;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (phase_valid !== 1'b0 || meas_timeout !== 1'b0)) begin
            checks++;
            mon_err = phase_err;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: valid=%0b timeout=%0b err=%0d cyc=%0d, required no strobe",
                         phase_valid, meas_timeout, mon_err, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (phase_valid !== !mon_e.tmo || meas_timeout !== mon_e.tmo ||
                    mon_err != mon_e.err || cyc != mon_e.at) begin
                    failures++;
                    $display("FAIL strobe: got valid=%0b timeout=%0b err=%0d cyc=%0d, required valid=%0b timeout=%0b err=%0d cyc=%0d",
                             phase_valid, meas_timeout, mon_err, cyc,
                             !mon_e.tmo, mon_e.tmo, mon_e.err, mon_e.at);
                end
            end
        end
    end

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic bit hi(input int s, input int t);
        return (s >= 0) && (t >= s) && (t < s + 5);
    endfunction

    // Drive 5-cycle-wide pulses starting at the given cycle offsets (-1 = none)
    task automatic drive_edges(input int g1, input int g2, input int l1,
                               input int l2, input int len);
        for (int t = 0; t < len; t++) begin
            gps = hi(g1, t) || hi(g2, t);
            loc = hi(l1, t) || hi(l2, t);
            @(negedge clk);
        end
        gps = 1'b0;
        loc = 1'b0;
    endtask

    task automatic push_exp(input bit tmo, input longint err, input longint at);
        exp_t e;
        if (!tmo) exp_last_err = err;
        e.tmo = tmo;
        e.err = tmo ? exp_last_err : err;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d strobes still pending after %0d cycles, required 0",
                     exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        longint p0;
        int     m;
        p0 = cyc;
        m  = v.g1;
        if (v.g2 > m) m = v.g2;
        if (v.l1 > m) m = v.l1;
        if (v.l2 > m) m = v.l2;
        if (v.push) push_exp(v.tmo, v.err, p0 + v.close_t + LAT);
        drive_edges(v.g1, v.g2, v.l1, v.l2, m + 8);
        wait_drain(2 * MAX_WIN + 200);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #(900_000);
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs[$];
        longint p0;

`ifdef PHASE_AVG_EN
        vecs.push_back('{"avg_a1",      0, -1, 10, -1, 1'b0, 1'b0,  0,  10});
        vecs.push_back('{"avg_a2",      0, -1, 11, -1, 1'b0, 1'b0,  0,  11});
        vecs.push_back('{"avg_a3",      3, -1,  0, -1, 1'b0, 1'b0,  0,   3});
        vecs.push_back('{"avg_a4",      0, -1,  5, -1, 1'b1, 1'b0,  5,   5});
        vecs.push_back('{"avg_b1",      1, -1,  0, -1, 1'b0, 1'b0,  0,   1});
        vecs.push_back('{"avg_b2",      1, -1,  0, -1, 1'b0, 1'b0,  0,   1});
        vecs.push_back('{"avg_b3",      1, -1,  0, -1, 1'b0, 1'b0,  0,   1});
        vecs.push_back('{"avg_b4",      2, -1,  0, -1, 1'b1, 1'b0, -2,   2});
`else
        vecs.push_back('{"gps_lead_max",   0,  -1, 1000,  -1, 1'b1, 1'b0,  1000, 1000});
        vecs.push_back('{"loc_lead_37",   37,  -1,    0,  -1, 1'b1, 1'b0,   -37,   37});
        vecs.push_back('{"same_cycle",     0,  -1,    0,  -1, 1'b1, 1'b0,     0,    0});
        vecs.push_back('{"gps_restart",    0, 500,  520,  -1, 1'b1, 1'b0,    20,  520});
        vecs.push_back('{"gps_lead_1",     0,  -1,    1,  -1, 1'b1, 1'b0,     1,    1});
        vecs.push_back('{"loc_lead_1",     1,  -1,    0,  -1, 1'b1, 1'b0,    -1,    1});
        vecs.push_back('{"loc_lead_max", 1000, -1,    0,  -1, 1'b1, 1'b0, -1000, 1000});
        vecs.push_back('{"overlap_3",      0,  -1,    3,  -1, 1'b1, 1'b0,     3,    3});
        vecs.push_back('{"loc_restart",  130,  -1,    0, 100, 1'b1, 1'b0,   -30,  130});
        vecs.push_back('{"close_and_open", 0,  50,   50,  -1, 1'b1, 1'b0,    50,   50});
        vecs.push_back('{"gps_only_tmo",   0,  -1,   -1,  -1, 1'b1, 1'b1,     0, 1000});
        vecs.push_back('{"loc_only_tmo",  -1,  -1,    0,  -1, 1'b1, 1'b1,     0, 1000});
`endif

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_phase_err", phase_err, 0);
        chk("reset_phase_valid", phase_valid, 0);
        chk("reset_meas_timeout", meas_timeout, 0);
        chk("reset_gps_lost", gps_lost, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Reset pulsed while waiting for the local edge: no strobe, reset values
        drive_edges(0, -1, -1, -1, 100);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_phase_err", phase_err, 0);
        chk("midrst_phase_valid", phase_valid, 0);
        chk("midrst_meas_timeout", meas_timeout, 0);
        chk("midrst_gps_lost", gps_lost, 1);
        exp_last_err = 0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Lone GPS edge: timeout at MAX_WIN, gps_lost clears then re-asserts
        p0 = cyc;
        push_exp(1'b1, 0, p0 + MAX_WIN + LAT);
        gps = 1'b1;
        repeat (3) @(negedge clk);
        chk("lost_before_pulse", gps_lost, 1);
        @(negedge clk);
        chk("lost_cleared", gps_lost, 0);
        @(negedge clk);
        gps = 1'b0;
        while (cyc < p0 + LOSS_CYC + LAT - 1) @(negedge clk);
        chk("lost_just_before", gps_lost, 0);
        @(negedge clk);
        chk("lost_reasserted", gps_lost, 1);
        wait_drain(2 * MAX_WIN + 200);
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
